decode_div_70s_31ns_40_seq: RTL and testbench
=============================================

DECODE_DIV_70S_31NS_40_SEQ -- requirements
Module: decode_div_70s_31ns_40_seq

Interface
REQ-001 SHALL have parameter ID, default 1, instance tag with no functional effect.
REQ-002 SHALL have parameter din0_WIDTH, default 70, dividend width (signed).
REQ-003 SHALL have parameter din1_WIDTH, default 31, divisor width (unsigned).
REQ-004 SHALL have parameter dout_WIDTH, default 40, quotient width (signed).
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port ce, input, 1 bit: clock enable; when low, all state and outputs hold.
REQ-008 SHALL have port start, input, 1 bit: request to begin a division.
REQ-009 SHALL have port ready, output, 1 bit: high only in IDLE.
REQ-010 SHALL have port din0, input, din0_WIDTH bits: signed dividend.
REQ-011 SHALL have port din1, input, din1_WIDTH bits: unsigned divisor.
REQ-012 SHALL have port done, output, 1 bit: one-cycle result-valid strobe.
REQ-013 SHALL have port dout, output, dout_WIDTH bits: signed quotient.
REQ-014 SHALL have port rem, output, din1_WIDTH+1 bits: signed remainder.
REQ-015 SHALL have port div_zero, output, 1 bit: divisor was zero.
REQ-016 SHALL have port ovf, output, 1 bit: quotient saturated.

Function
REQ-017 SHALL use states IDLE, CALC, FIX and DONE, and only advance when ce=1.
REQ-018 SHALL accept start only when ce=1 in IDLE, capturing din0/din1 at that edge (edge 0); start in any other state SHALL be ignored.
REQ-019 SHALL, on acceptance with din1!=0, go to CALC and perform one restoring-division step on |din0| per ce-qualified edge, 70 steps on edges 1..70, then enter FIX.
REQ-020 SHALL, on acceptance with din1==0, go directly to FIX with no CALC steps.
REQ-021 SHALL, on the FIX edge, register dout, rem, div_zero and ovf, assert done, and enter DONE.
REQ-022 SHALL, on the next ce-qualified edge after DONE, deassert done and enter IDLE.
REQ-023 SHALL produce done high for exactly one ce-qualified cycle: 72 edges after acceptance for a normal division and 2 edges after acceptance for divide-by-zero.
REQ-024 SHALL truncate toward zero: quotient sign = sign(din0); remainder sign = sign(din0); |rem| < din1; din0 = q*din1 + rem when not saturated.
REQ-025 SHALL, when the true quotient exceeds 2^39-1, output 0x7FFFFFFFFF with ovf=1.
REQ-026 SHALL, when the true quotient is below -2^39, output -2^39 with ovf=1; a quotient of exactly -2^39 SHALL give ovf=0.
REQ-027 SHALL, for divide-by-zero, output dout=0, rem=0, div_zero=1, ovf=0.
REQ-028 SHALL hold dout, rem, div_zero and ovf stable from the FIX edge until the next FIX edge.
REQ-029 SHALL, when ce=0 in any state, freeze the state, the iteration count and done, which extends the latency by the number of ce-low cycles.

Reset
REQ-030 SHALL, on reset low, immediately force IDLE, ready=1, done=0, dout=0, rem=0, div_zero=0, ovf=0 and clear the iteration count, independent of clk and ce.
REQ-031 SHALL, on reset during CALC/FIX/DONE, discard the in-flight operation with no done pulse; the first start accepted after reset release SHALL begin a fresh division.

Verification
REQ-032 SHALL cover: din0=100, din1=7, ce=1 -> done at edge 72, dout=14, rem=2, flags 0.
REQ-033 SHALL cover: din0=-100, din1=7 -> dout=-14, rem=-2; din0=-7, din1=7 -> dout=-1, rem=0.
REQ-034 SHALL cover: din0=12345, din1=0 -> done at edge 2, dout=0, rem=0, div_zero=1, ovf=0.
REQ-035 SHALL cover: din0=2^60, din1=1 -> dout=0x7FFFFFFFFF, ovf=1; din0=-2^39, din1=1 -> dout=-2^39, ovf=0; din0=-2^39-1, din1=1 -> dout=-2^39, ovf=1.
REQ-036 SHALL cover: 100/7 with ce held low for 10 cycles during CALC -> done at edge 82 with the same result; start pulsed during CALC -> ignored.
REQ-037 SHALL cover: reset asserted at CALC edge 30 -> all outputs 0, ready=1, no done; then 100/7 -> correct result at edge 72 after acceptance.

Source files
------------

// File: rtl/decode_div_70s_31ns_40_seq.sv
//------------------------------------------------------------------------------
// decode_div_70s_31ns_40_seq
//
// Multi-cycle restoring divider with a signed dividend and an unsigned divisor.
// The division is done on |din0| at one quotient bit per clock-enabled edge.
// The sign is applied afterwards, and the quotient saturates to the signed
// range of dout. The quotient and the remainder both truncate toward zero, so
// both take the sign of the dividend.
//
// Timing, with edge 0 being the edge that accepts start:
//   din1 != 0 : edges 1..din0_WIDTH perform the shift/subtract steps, the next
//               edge (FIX) registers the result and raises done, and the edge
//               after that (DONE) drops done again.
//   din1 == 0 : edge 1 is the FIX edge. No shift/subtract steps are run.
// When ce is low, all state holds. This stretches the latency by the number
// of ce-low cycles.
//
// Ports
//   clk      in   rising-edge clock
//   reset    in   asynchronous, active-low reset
//   ce       in   clock enable, gates every state change
//   start    in   begin a division. Only accepted while ready is high.
//   ready    out  high only while IDLE
//   din0     in   signed dividend, captured when start is accepted
//   din1     in   unsigned divisor, captured when start is accepted
//   done     out  one-cycle result-valid strobe
//   dout     out  signed quotient (saturated)
//   rem      out  signed remainder, din1_WIDTH+1 bits
//   div_zero out  the divisor was zero
//   ovf      out  the quotient saturated
//------------------------------------------------------------------------------
module decode_div_70s_31ns_40_seq #(
    parameter int ID         = 1,
    parameter int din0_WIDTH = 70,
    parameter int din1_WIDTH = 31,
    parameter int dout_WIDTH = 40
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic                  start,
    output logic                  ready,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic                  done,
    output logic [dout_WIDTH-1:0] dout,
    output logic [din1_WIDTH:0]   rem,
    output logic                  div_zero,
    output logic                  ovf
);

    localparam int W0 = din0_WIDTH;
    localparam int W1 = din1_WIDTH;
    localparam int WO = dout_WIDTH;
    localparam int CW = $clog2(W0 + 1);

    // The step counter is compared with this value to detect the last step.
    localparam logic [CW-1:0] LAST_STEP = CW'(W0 - 1);

    // These limits are quotient magnitudes, at full dividend width.
    // Positive results saturate above 2^(WO-1)-1. Negative results saturate
    // only above 2^(WO-1), because -2^(WO-1) itself can be represented.
    localparam logic [W0-1:0] Q_POS_MAX = (W0'(1) << (WO - 1)) - W0'(1);
    localparam logic [W0-1:0] Q_NEG_MAG = W0'(1) << (WO - 1);

    // ID is only an instance tag. This reference ties it to the elaboration
    // without creating any logic.
    if (ID < 0) begin : g_id_tag_only
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t          r_state;
    logic            r_ready;
    logic            r_done;
    logic [WO-1:0]   r_dout;
    logic [W1:0]     r_rem;
    logic            r_div_zero;
    logic            r_ovf;

    // Datapath of the operation in progress
    logic [CW-1:0]   r_cnt;     // number of shift/subtract steps completed
    logic [W0-1:0]   r_quo;     // |dividend| shifts out at the top, quotient bits enter at the bottom
    logic [W1:0]     r_part;    // partial remainder, always < divisor
    logic [W1-1:0]   r_div;     // captured divisor
    logic            r_neg;     // dividend was negative
    logic            r_zero;    // divisor was zero

    logic [W0-1:0]   w_abs;
    logic [W1:0]     w_shift;
    logic [W1:0]     w_sub;
    logic            w_ge;
    logic [WO-1:0]   w_q_low;
    logic            w_q_pos_ovf;
    logic            w_q_neg_ovf;
    logic [WO-1:0]   w_dout_fix;
    logic [W1:0]     w_rem_fix;

    // |din0|. For the most negative dividend the two's complement wraps to
    // 2^(W0-1). That value is still correct when read as unsigned.
    assign w_abs = din0[W0-1] ? ((~din0) + W0'(1)) : din0;

    // A single restoring step: bring the next dividend bit into the partial
    // remainder, then subtract the divisor if it fits.
    assign w_shift = {r_part[W1-1:0], r_quo[W0-1]};
    assign w_ge    = (w_shift >= {1'b0, r_div});
    assign w_sub   = w_shift - {1'b0, r_div};

    // Sign correction and saturation, used on the FIX edge
    assign w_q_low     = r_quo[WO-1:0];
    assign w_q_pos_ovf = !r_neg && (r_quo > Q_POS_MAX);
    assign w_q_neg_ovf =  r_neg && (r_quo > Q_NEG_MAG);
    assign w_rem_fix   = r_neg ? ((~r_part) + (W1+1)'(1)) : r_part;

    always_comb begin
        // NOTE: assign a default before the branches. A combinational output
        // left unassigned on any path infers a latch.
        w_dout_fix = w_q_low;
        if (w_q_pos_ovf) begin
            w_dout_fix = {1'b0, {(WO-1){1'b1}}};
        end else if (w_q_neg_ovf) begin
            w_dout_fix = {1'b1, {(WO-1){1'b0}}};
        end else if (r_neg) begin
            // A magnitude of exactly 2^(WO-1) negates to itself, which is -2^(WO-1).
            w_dout_fix = (~w_q_low) + WO'(1);
        end
    end

    // Control FSM, the datapath and the registered outputs, all in one
    // clocked process.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: the datapath registers are reset as well as the control
            // registers. This makes an aborted division leave no trace in the
            // outputs or in the next operation.
            r_state    <= IDLE;
            r_ready    <= 1'b1;
            r_done     <= 1'b0;
            r_dout     <= '0;
            r_rem      <= '0;
            r_div_zero <= 1'b0;
            r_ovf      <= 1'b0;
            r_cnt      <= '0;
            r_quo      <= '0;
            r_part     <= '0;
            r_div      <= '0;
            r_neg      <= 1'b0;
            r_zero     <= 1'b0;
        end else if (ce) begin
            // NOTE: clocked state uses non-blocking assignments only. Every
            // right-hand side therefore reads the value from before this edge.
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_ready <= 1'b0;
                        r_neg   <= din0[W0-1];
                        r_quo   <= w_abs;
                        r_div   <= din1;
                        r_part  <= '0;
                        r_cnt   <= '0;
                        r_zero  <= (din1 == '0);
                        r_state <= (din1 == '0) ? FIX : CALC;
                    end
                end

                CALC: begin
                    r_quo  <= {r_quo[W0-2:0], w_ge};
                    r_part <= w_ge ? w_sub : w_shift;
                    r_cnt  <= r_cnt + CW'(1);
                    if (r_cnt == LAST_STEP) begin
                        r_state <= FIX;
                    end
                end

                FIX: begin
                    if (r_zero) begin
                        r_dout     <= '0;
                        r_rem      <= '0;
                        r_div_zero <= 1'b1;
                        r_ovf      <= 1'b0;
                    end else begin
                        r_dout     <= w_dout_fix;
                        r_rem      <= w_rem_fix;
                        r_div_zero <= 1'b0;
                        r_ovf      <= w_q_pos_ovf | w_q_neg_ovf;
                    end
                    r_done  <= 1'b1;
                    r_state <= DONE;
                end

                DONE: begin
                    r_done  <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= IDLE;
                end

                default: begin
                    r_done  <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign ready    = r_ready;
    assign done     = r_done;
    assign dout     = r_dout;
    assign rem      = r_rem;
    assign div_zero = r_div_zero;
    assign ovf      = r_ovf;

endmodule

// File: tb/tb_decode_div_70s_31ns_40_seq.sv
//------------------------------------------------------------------------------
// Testbench for decode_div_70s_31ns_40_seq.
// Edge numbering: edge 0 is the posedge that accepts start. "done at edge N"
// means edge N is the edge that samples done high, so done rose after edge
// N-1. Outputs are sampled on the falling edge.
//------------------------------------------------------------------------------
module tb_decode_div_70s_31ns_40_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        ce;
    logic        start;
    logic        ready;
    logic [69:0] din0;
    logic [30:0] din1;
    logic        done;
    logic [39:0] dout;
    logic [31:0] rem;
    logic        div_zero;
    logic        ovf;

    int n_cmp = 0;
    int n_bad = 0;

    decode_div_70s_31ns_40_seq #(
        .ID(1), .din0_WIDTH(70), .din1_WIDTH(31), .dout_WIDTH(40)
    ) dut (
        .clk(clk), .reset(reset), .ce(ce), .start(start), .ready(ready),
        .din0(din0), .din1(din1), .done(done), .dout(dout), .rem(rem),
        .div_zero(div_zero), .ovf(ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [69:0] a;
        logic [30:0] b;
        logic [39:0] q;
        logic [31:0] r;
        bit          dz;
        bit          ov;
    } vec_t;

    task automatic check(input string name, input logic [79:0] got, input logic [79:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Reference model. It divides at full signed width and then saturates to 40 bits.
    function automatic void model(input logic [69:0] a, input logic [30:0] b,
                                  output logic [39:0] q, output logic [31:0] r,
                                  output bit dz, output bit ov);
        logic signed [79:0] sa, sb, sq, sr;
        if (b == 31'd0) begin
            q = '0; r = '0; dz = 1'b1; ov = 1'b0;
            return;
        end
        sa = {{10{a[69]}}, a};
        sb = {49'd0, b};
        sq = sa / sb;
        sr = sa % sb;
        dz = 1'b0;
        if (sq > 80'sh7F_FFFF_FFFF) begin
            q = 40'h7F_FFFF_FFFF; ov = 1'b1;
        end else if (sq < -80'sh80_0000_0000) begin
            q = 40'h80_0000_0000; ov = 1'b1;
        end else begin
            q = sq[39:0]; ov = 1'b0;
        end
        r = sr[31:0];
    endfunction

    // Runs a single division and returns the observed results and the edge
    // at which done is sampled. ce is held low for hold_len edges after edge
    // hold_at. When poke is set, start is pulsed during CALC along with a
    // different dividend.
    task automatic do_div(input logic [69:0] a, input logic [30:0] b,
                          input int hold_at, input int hold_len, input bit poke,
                          output logic [39:0] q, output logic [31:0] r,
                          output bit dz, output bit ov, output int seen, output int highs);
        int guard = 0;
        seen  = -1;
        highs = 0;
        while (!ready && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        din0  = a;
        din1  = b;
        start = 1'b1;
        ce    = 1'b1;
        @(posedge clk);            // edge 0
        @(negedge clk);
        start = 1'b0;
        din0  = {$urandom, $urandom, $urandom};
        din1  = 31'($urandom);
        for (int k = 1; k <= 300; k++) begin
            if (done) begin
                highs++;
                if (seen < 0) seen = k;
            end else if (highs > 0) begin
                check("ready_after_done", 80'(ready), 80'd1);
                break;
            end
            if (k == 3) check("ready_busy", 80'(ready), 80'd0);
            ce    = (hold_len > 0 && k > hold_at && k <= hold_at + hold_len) ? 1'b0 : 1'b1;
            start = poke && (k == 5);
            @(posedge clk);
            @(negedge clk);
        end
        ce    = 1'b1;
        start = 1'b0;
        q  = dout;
        r  = rem;
        dz = div_zero;
        ov = ovf;
    endtask

    task automatic run_and_check(input string tag, input logic [69:0] a, input logic [30:0] b,
                                 input logic [39:0] eq, input logic [31:0] er,
                                 input bit edz, input bit eov, input int eedge,
                                 input int hold_at, input int hold_len, input bit poke);
        logic [39:0] q;
        logic [31:0] r;
        bit dz, ov;
        int seen, highs;
        do_div(a, b, hold_at, hold_len, poke, q, r, dz, ov, seen, highs);
        check({tag, ".dout"},     80'(q),     80'(eq));
        check({tag, ".rem"},      80'(r),     80'(er));
        check({tag, ".div_zero"}, 80'(dz),    80'(edz));
        check({tag, ".ovf"},      80'(ov),    80'(eov));
        check({tag, ".done_edge"},  80'(seen),  80'(eedge));
        check({tag, ".done_width"}, 80'(highs), 80'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[8];
        logic [39:0] q;
        logic [31:0] r;
        bit dz, ov;
        int cnt;

        tbl[0] = '{a: 70'sd100,  b: 31'd7,   q: 40'd14,            r: 32'd2,            dz: 0, ov: 0};
        tbl[1] = '{a: -70'sd100, b: 31'd7,   q: 40'hFF_FFFF_FFF2,  r: 32'hFFFF_FFFE,    dz: 0, ov: 0};
        tbl[2] = '{a: -70'sd7,   b: 31'd7,   q: 40'hFF_FFFF_FFFF,  r: 32'd0,            dz: 0, ov: 0};
        tbl[3] = '{a: 70'sd12345, b: 31'd0,  q: 40'd0,             r: 32'd0,            dz: 1, ov: 0};
        tbl[4] = '{a: 70'sd1152921504606846976, b: 31'd1, q: 40'h7F_FFFF_FFFF, r: 32'd0, dz: 0, ov: 1};
        tbl[5] = '{a: -70'sd549755813888, b: 31'd1, q: 40'h80_0000_0000, r: 32'd0, dz: 0, ov: 0};
        tbl[6] = '{a: -70'sd549755813889, b: 31'd1, q: 40'h80_0000_0000, r: 32'd0, dz: 0, ov: 1};
        tbl[7] = '{a: 70'sd7,    b: 31'd100, q: 40'd0,             r: 32'd7,            dz: 0, ov: 0};

        reset = 1'b0;
        ce    = 1'b1;
        start = 1'b0;
        din0  = '0;
        din1  = '0;
        repeat (3) @(negedge clk);
        check("rst.ready",    80'(ready),    80'd1);
        check("rst.done",     80'(done),     80'd0);
        check("rst.dout",     80'(dout),     80'd0);
        check("rst.rem",      80'(rem),      80'd0);
        check("rst.div_zero", 80'(div_zero), 80'd0);
        check("rst.ovf",      80'(ovf),      80'd0);
        reset = 1'b1;
        @(negedge clk);

        // Directed vectors from the table
        for (int i = 0; i < 8; i++) begin
            run_and_check($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].r,
                          tbl[i].dz, tbl[i].ov, (tbl[i].b == 31'd0) ? 2 : 72, 0, 0, 1'b0);
        end

        // The result must stay held while idle
        repeat (5) @(negedge clk);
        check("hold.dout", 80'(dout), 80'(tbl[7].q));
        check("hold.rem",  80'(rem),  80'(tbl[7].r));

        // Randomized operands compared against the model
        for (int i = 0; i < 24; i++) begin
            logic [69:0] a;
            logic [30:0] b;
            a = 70'({$urandom, $urandom, $urandom}) >> $urandom_range(0, 69);
            if ($urandom_range(0, 1) == 1) a = -a;
            b = 31'($urandom) >> $urandom_range(0, 30);
            if ($urandom_range(0, 7) == 0) b = '0;
            model(a, b, q, r, dz, ov);
            run_and_check($sformatf("rnd%0d", i), a, b, q, r, dz, ov,
                          (b == 31'd0) ? 2 : 72, 0, 0, 1'b0);
        end

        // ce held low for 10 cycles in CALC, with a start pulse that must be ignored
        run_and_check("ce_hold", 70'd100, 31'd7, 40'd14, 32'd2, 1'b0, 1'b0, 82, 20, 10, 1'b1);

        // Reset asserted in the middle of CALC
        din0  = 70'd100;
        din1  = 31'd7;
        start = 1'b1;
        @(posedge clk);            // edge 0
        @(negedge clk);
        start = 1'b0;
        repeat (30) begin
            @(posedge clk);
            @(negedge clk);
        end
        reset = 1'b0;
        #1;
        check("abort.ready",    80'(ready),    80'd1);
        check("abort.done",     80'(done),     80'd0);
        check("abort.dout",     80'(dout),     80'd0);
        check("abort.rem",      80'(rem),      80'd0);
        check("abort.div_zero", 80'(div_zero), 80'd0);
        check("abort.ovf",      80'(ovf),      80'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        cnt = 0;
        for (int k = 0; k < 90; k++) begin
            @(negedge clk);
            if (done) cnt++;
        end
        check("abort.no_done", 80'(cnt), 80'd0);
        run_and_check("after_abort", 70'd100, 31'd7, 40'd14, 32'd2, 1'b0, 1'b0, 72, 0, 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
